// File: rtl/rename_pkg.sv
// Shared constants and helpers for the register-rename stage.
package rename_pkg;

    localparam int ARCH_REGS      = 32;
    localparam int PHYS_REGS      = 64;
    localparam int PREG_W         = 6;
    localparam int AREG_W         = 5;
    localparam int FL_INIT        = PHYS_REGS - ARCH_REGS;
    localparam int C_SIG_REGWRITE = 0;
    localparam int RS1_LSB        = 15;
    localparam int RS2_LSB        = 20;
    localparam int RD_LSB         = 7;

    function automatic logic [AREG_W-1:0] areg_field(
        input logic [31:0] instr,
        input int unsigned lsb
    );
        return instr[lsb +: AREG_W];
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical tags; resets holding p32..p63.
module free_list
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [PREG_W-1:0] push_preg,
    input  logic              pop,
    output logic [PREG_W-1:0] head,
    output logic [PREG_W:0]   count,
    output logic              empty,
    output logic              full
);

    logic [PREG_W-1:0] mem [PHYS_REGS];
    logic [PREG_W-1:0] rd_ptr;
    logic [PREG_W-1:0] wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PREG_W+1)'(PHYS_REGS));
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are PREG_W wide, so they wrap modulo PHYS_REGS for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHYS_REGS; i++)
                mem[i] <= (i < FL_INIT) ? PREG_W'(FL_INIT + i) : '0;
            rd_ptr <= '0;
            wr_ptr <= PREG_W'(FL_INIT);
            count  <= (PREG_W+1)'(FL_INIT);
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_preg;
                wr_ptr      <= wr_ptr + PREG_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PREG_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: RAT lookup, destination allocation, registered output slot.
module rename_stage
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [31:0]       d_instr,
    input  logic [6:0]        d_c_sig,
    input  logic [2:0]        d_alu_sig,
    input  logic [31:0]       d_imm,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [31:0]       r_instr,
    output logic [6:0]        r_c_sig,
    output logic [2:0]        r_alu_sig,
    output logic [31:0]       r_imm,
    output logic [PREG_W-1:0] r_prs1,
    output logic [PREG_W-1:0] r_prs2,
    output logic [PREG_W-1:0] r_prd,
    output logic [PREG_W-1:0] r_old_prd,
    output logic              r_has_rd,
    input  logic              ret_valid,
    input  logic [PREG_W-1:0] ret_preg
);

    logic [PREG_W-1:0] rat [ARCH_REGS];
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic              alloc;
    logic              slot_free;
    logic              accept;
    logic              fl_push;
    logic              fl_pop;
    logic [PREG_W-1:0] fl_head;
    logic [PREG_W:0]   fl_count;
    logic              fl_empty;
    logic              fl_full;

    assign rs1       = areg_field(d_instr, RS1_LSB);
    assign rs2       = areg_field(d_instr, RS2_LSB);
    assign rd        = areg_field(d_instr, RD_LSB);
    assign alloc     = d_c_sig[C_SIG_REGWRITE] && (rd != '0);
    assign slot_free = !r_valid || r_ready;
    assign d_ready   = slot_free && !fl_empty;
    assign accept    = d_valid && d_ready;
    assign fl_pop    = accept && alloc;
    assign fl_push   = ret_valid && (ret_preg != '0);

    free_list u_free_list (
        .clk       (clk),
        .rst       (rst),
        .push      (fl_push),
        .push_preg (ret_preg),
        .pop       (fl_pop),
        .head      (fl_head),
        .count     (fl_count),
        .empty     (fl_empty),
        .full      (fl_full)
    );

    // Sources read the pre-update RAT, so rs==rd sees the old mapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                rat[i] <= PREG_W'(i);
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_c_sig   <= '0;
            r_alu_sig <= '0;
            r_imm     <= '0;
            r_prs1    <= '0;
            r_prs2    <= '0;
            r_prd     <= '0;
            r_old_prd <= '0;
            r_has_rd  <= 1'b0;
        end else if (accept) begin
            r_valid   <= 1'b1;
            r_instr   <= d_instr;
            r_c_sig   <= d_c_sig;
            r_alu_sig <= d_alu_sig;
            r_imm     <= d_imm;
            r_prs1    <= rat[rs1];
            r_prs2    <= rat[rs2];
            r_prd     <= alloc ? fl_head : '0;
            r_old_prd <= alloc ? rat[rd] : '0;
            r_has_rd  <= alloc;
            if (alloc)
                rat[rd] <= fl_head;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A retire push into a full list is a pipeline bookkeeping bug.
    assert property (@(posedge clk) disable iff (!rst) !(fl_push && fl_full));
    assert property (@(posedge clk) disable iff (!rst)
        fl_empty == (fl_count == '0));

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed cases plus random traffic
// checked against a queue/array model of the RAT and free list.
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [6:0]  d_c_sig;
    logic [2:0]  d_alu_sig;
    logic [31:0] d_imm;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_instr;
    logic [6:0]  r_c_sig;
    logic [2:0]  r_alu_sig;
    logic [31:0] r_imm;
    logic [5:0]  r_prs1;
    logic [5:0]  r_prs2;
    logic [5:0]  r_prd;
    logic [5:0]  r_old_prd;
    logic        r_has_rd;
    logic        ret_valid;
    logic [5:0]  ret_preg;

    rename_stage dut (
        .clk       (clk),
        .rst       (rst),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_instr   (d_instr),
        .d_c_sig   (d_c_sig),
        .d_alu_sig (d_alu_sig),
        .d_imm     (d_imm),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_instr   (r_instr),
        .r_c_sig   (r_c_sig),
        .r_alu_sig (r_alu_sig),
        .r_imm     (r_imm),
        .r_prs1    (r_prs1),
        .r_prs2    (r_prs2),
        .r_prd     (r_prd),
        .r_old_prd (r_old_prd),
        .r_has_rd  (r_has_rd),
        .ret_valid (ret_valid),
        .ret_preg  (ret_preg)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model state: architectural map, free queue, output slot contents.
    int          rat [32];
    int          fq [$];
    int          retq [$];
    bit          mv;
    logic [31:0] m_instr;
    logic [6:0]  m_csig;
    logic [2:0]  m_alu;
    logic [31:0] m_imm;
    int          m_prs1;
    int          m_prs2;
    int          m_prd;
    int          m_old;
    bit          m_has;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1,
                                       input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic bit model_dready();
        return (!mv || r_ready) && (fq.size() != 0);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) rat[i] = i;
        fq.delete();
        for (int i = 32; i < 64; i++) fq.push_back(i);
        retq.delete();
        mv = 1'b0;
    endfunction

    function automatic void model_step();
        int rd;
        if (d_valid && model_dready()) begin
            mv      = 1'b1;
            m_instr = d_instr;
            m_csig  = d_c_sig;
            m_alu   = d_alu_sig;
            m_imm   = d_imm;
            m_prs1  = rat[d_instr[19:15]];
            m_prs2  = rat[d_instr[24:20]];
            rd      = int'(d_instr[11:7]);
            if (d_c_sig[0] && rd != 0) begin
                m_prd   = fq.pop_front();
                m_old   = rat[rd];
                rat[rd] = m_prd;
                m_has   = 1'b1;
                retq.push_back(m_old);
            end else begin
                m_prd = 0;
                m_old = 0;
                m_has = 1'b0;
            end
        end else if (r_ready) begin
            mv = 1'b0;
        end
        if (ret_valid && ret_preg != 0) fq.push_back(int'(ret_preg));
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("r_valid", 32'(r_valid), 32'(mv));
            check("d_ready", 32'(d_ready), 32'(model_dready()));
            if (mv) begin
                check("r_instr", r_instr, m_instr);
                check("r_c_sig", 32'(r_c_sig), 32'(m_csig));
                check("r_alu_sig", 32'(r_alu_sig), 32'(m_alu));
                check("r_imm", r_imm, m_imm);
                check("r_prs1", 32'(r_prs1), 32'(m_prs1));
                check("r_prs2", 32'(r_prs2), 32'(m_prs2));
                check("r_prd", 32'(r_prd), 32'(m_prd));
                check("r_old_prd", 32'(r_old_prd), 32'(m_old));
                check("r_has_rd", 32'(r_has_rd), 32'(m_has));
            end
        end
    end

    task automatic drive(input logic dv, input logic [31:0] ins,
                         input logic [6:0] cs, input logic rr,
                         input logic rv, input logic [5:0] rp);
        d_valid   = dv;
        d_instr   = ins;
        d_c_sig   = cs;
        d_alu_sig = ins[14:12];
        d_imm     = ins ^ 32'h5a5a_0f0f;
        r_ready   = rr;
        ret_valid = rv;
        ret_preg  = rp;
    endtask

    task automatic step(input logic dv, input logic [31:0] ins,
                        input logic [6:0] cs, input logic rr,
                        input logic rv, input logic [5:0] rp);
        drive(dv, ins, cs, rr, rv, rp);
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    initial begin
        logic [31:0] ia;
        logic [31:0] ib;
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_prd", 32'(r_prd), 32'd0);
        check("rst_r_instr", r_instr, 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd1);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // add x5,x1,x2 then sub x6,x5,x5
        step(1'b1, mk(5, 1, 2), 7'h01, 1'b1, 1'b0, '0);
        check("t1_prs1", 32'(r_prs1), 32'd1);
        check("t1_prs2", 32'(r_prs2), 32'd2);
        check("t1_prd", 32'(r_prd), 32'd32);
        check("t1_old", 32'(r_old_prd), 32'd5);
        check("t1_has", 32'(r_has_rd), 32'd1);
        step(1'b1, mk(6, 5, 5), 7'h01, 1'b1, 1'b0, '0);
        check("t2_prs1", 32'(r_prs1), 32'd32);
        check("t2_prs2", 32'(r_prs2), 32'd32);
        check("t2_prd", 32'(r_prd), 32'd33);
        check("t2_old", 32'(r_old_prd), 32'd6);

        // No allocation for rd=x0 or RegWrite=0; head must not move.
        step(1'b1, mk(0, 6, 1), 7'h01, 1'b1, 1'b0, '0);
        check("t3_x0_prd", 32'(r_prd), 32'd0);
        check("t3_x0_has", 32'(r_has_rd), 32'd0);
        check("t3_x0_prs1", 32'(r_prs1), 32'd33);
        step(1'b1, mk(7, 1, 1), 7'h7e, 1'b1, 1'b0, '0);
        check("t3_nowr_prd", 32'(r_prd), 32'd0);
        check("t3_nowr_old", 32'(r_old_prd), 32'd0);
        step(1'b1, mk(8, 1, 2), 7'h01, 1'b1, 1'b0, '0);
        check("t3_next_prd", 32'(r_prd), 32'd34);

        // Drain the remaining 29 free tags.
        for (int i = 0; i < 29; i++)
            step(1'b1, mk(9 + (i % 23), 1, 2), 7'h01, 1'b1, 1'b0, '0);
        check("t4_last_prd", 32'(r_prd), 32'd63);
        drive(1'b1, mk(10, 1, 2), 7'h01, 1'b1, 1'b0, '0);
        #1;
        check("t4_exhaust", 32'(d_ready), 32'd0);
        void'(retq.pop_front());
        drive(1'b1, mk(10, 1, 2), 7'h01, 1'b1, 1'b1, 6'd5);
        #1;
        check("t4_no_bypass", 32'(d_ready), 32'd0);
        step(1'b1, mk(10, 1, 2), 7'h01, 1'b1, 1'b1, 6'd5);
        check("t4_stall_valid", 32'(r_valid), 32'd0);
        step(1'b1, mk(10, 1, 2), 7'h01, 1'b1, 1'b0, '0);
        check("t4_refill_prd", 32'(r_prd), 32'd5);

        for (int i = 0; i < 8; i++)
            step(1'b0, '0, '0, 1'b1, 1'b1, 6'(retq.pop_front()));

        // Backpressure: slot holds A while B waits.
        ia = mk(11, 1, 2);
        ib = mk(12, 3, 4);
        step(1'b1, ia, 7'h01, 1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ib, 7'h01, 1'b0, 1'b0, '0);
            #1;
            check("t5_d_ready", 32'(d_ready), 32'd0);
            step(1'b1, ib, 7'h01, 1'b0, 1'b0, '0);
            check("t5_hold_valid", 32'(r_valid), 32'd1);
            check("t5_hold_instr", r_instr, ia);
        end
        step(1'b1, ib, 7'h01, 1'b1, 1'b0, '0);
        check("t5_resume_instr", r_instr, ib);
        check("t5_resume_valid", 32'(r_valid), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("t5_no_dup", 32'(r_valid), 32'd0);

        // Async reset between edges with an instruction in the slot.
        step(1'b1, mk(13, 1, 2), 7'h01, 1'b0, 1'b0, '0);
        check("t6_pre_valid", 32'(r_valid), 32'd1);
        #3;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_async_valid", 32'(r_valid), 32'd0);
        check("t6_async_prd", 32'(r_prd), 32'd0);
        check("t6_async_instr", r_instr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, mk(5, 5, 0), 7'h01, 1'b1, 1'b0, '0);
        check("t6_prs1", 32'(r_prs1), 32'd5);
        check("t6_prd", 32'(r_prd), 32'd32);

        // Random traffic, retiring old mappings in allocation order.
        for (int c = 0; c < 3000; c++) begin
            logic        rv;
            logic [5:0]  rp;
            rv = 1'b0;
            rp = '0;
            if (retq.size() != 0 && $urandom_range(0, 2) != 0) begin
                rv = 1'b1;
                rp = 6'(retq.pop_front());
            end else if ($urandom_range(0, 15) == 0) begin
                rv = 1'b1;
            end
            step($urandom_range(0, 3) != 0, $urandom(), 7'($urandom()),
                 $urandom_range(0, 3) != 0, rv, rp);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
